everloop_rx: RTL
================

Name: everloop_rx

Overview:
- Serial decoder for the single-wire NRZ LED protocol that the everloop transmitter drives on everloop_d. It is the receive end of that link.
- Measures high-pulse widths, recovers bits MSB-first, assembles bytes and writes them into a frame buffer. The write interface mirrors the transmitter's address/data_RGB read port.
- Used for transmitter loopback checking and for cascading a downstream LED-ring emulator.

Parameters:
- HI_THRESH, 28, high-pulse length in clk cycles at or above which a bit decodes as 1; below it decodes as 0.
- MAX_HI, 60, high pulses longer than this many cycles are protocol errors.
- RST_CYCLES, 2500, continuous low cycles that constitute a latch/reset gap (end of frame).
- NUM_BYTES, 140, frame buffer depth in bytes (35 LEDs x 4 bytes).
- ADDR_W, 8, address width; must satisfy 2^ADDR_W >= NUM_BYTES.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- everloop_d  input  1  serial LED data line (asynchronous to clk)
- address  output  ADDR_W  byte write address
- data_RGB  output  8  assembled byte, valid when wr_en=1
- wr_en  output  1  one-cycle write strobe
- frame_done  output  1  one-cycle pulse when a latch gap ends a frame containing at least 1 byte
- overflow  output  1  sticky; set when a byte arrives with address already at NUM_BYTES; cleared at the next frame_done or rst
- err  output  1  one-cycle pulse on a protocol error

Behaviour:
- Reset (rst sampled high at a rising edge) sets:
  - address=0, data_RGB=0, wr_en=0, frame_done=0, overflow=0, err=0
  - bit counter=0, shift register=0, all cycle counters=0
  - both synchronizer flops=0
  - state=SYNC
- Input path: 2-flop synchronizer, then an edge detector on the synchronized signal d_s. All timing below refers to d_s.
- State machine:
  - SYNC: wait for RST_CYCLES consecutive low cycles, then go to IDLE. Pulses seen in SYNC are ignored, with no err.
  - IDLE: on a d_s rising edge, clear hi_cnt and go to HIGH.
  - HIGH: hi_cnt increments every cycle.
    - If hi_cnt exceeds MAX_HI: pulse err, discard the partial byte, go to SYNC.
    - On a falling edge: bit = (hi_cnt >= HI_THRESH). Shift the bit into the LSB of the shift register (so the first bit received ends up as the MSB). Increment the bit counter, clear lo_cnt, go to LOW.
  - LOW: lo_cnt increments every cycle.
    - On a rising edge: go to HIGH.
    - If lo_cnt reaches RST_CYCLES: end of frame. Apply the end-of-frame rules below, then go to IDLE.
- Byte write: when the 8th bit is shifted in, on the next cycle:
  - data_RGB = assembled byte, wr_en=1 for exactly one cycle, address holds the write address.
  - address increments on the cycle after wr_en.
  - Latency: 4 clk cycles from the everloop_d falling edge of bit 8 to the wr_en cycle.
- Overflow: if address == NUM_BYTES when a byte completes:
  - no wr_en is issued and overflow is set;
  - address saturates at NUM_BYTES and never wraps.
- End of frame (lo_cnt reaches RST_CYCLES):
  - If the bit counter != 0, discard the partial byte and pulse err.
  - If at least 1 byte was written, pulse frame_done.
  - address returns to 0 and overflow clears (on the same cycle as frame_done).
  - Gaps with no bytes received produce no frame_done.
- Simultaneity:
  - frame_done and err may assert in the same cycle.
  - wr_en never coincides with frame_done, because the write is at most 1 cycle after bit 8 and the gap is at least RST_CYCLES long.
- Reset mid-frame: rst has priority in every state. Everything returns to reset values, and SYNC requires a full gap before decoding resumes.
- Counter widths: hi_cnt is sized for MAX_HI+1, lo_cnt for RST_CYCLES. Both saturate and never wrap.

Optional Feature:
- Macro: EVERLOOP_RX_GLITCH_EN
- Defined: a high pulse shorter than 4 cycles is treated as noise. The FSM returns to LOW (or IDLE), no bit is shifted, and lo_cnt resumes from its pre-glitch value plus the glitch length.
- Undefined: every high pulse of 1 or more cycles decodes as a bit; a 1-cycle pulse decodes as 0.

Test Plan:
- Reset/SYNC: hold rst for 2 cycles, then drive line low for 2500 cycles -> all outputs 0; a pulse sent before the gap completes gives no wr_en and no err.
- Single byte: send 0xAA (1 = 35 cycles high / 27 low, 0 = 14 high / 48 low), then a 2500-cycle low gap -> wr_en once, data_RGB=0xAA, address=0; frame_done pulses once; address returns to 0.
- Full frame: 140 bytes of value i (0..139) -> 140 wr_en strobes, address i carries data i, then a single frame_done.
- Overflow: send 141 bytes -> 140 writes; overflow=1 after byte 141 with no 141st wr_en; overflow clears on frame_done.
- Errors: a 70-cycle high pulse -> err pulse and return to SYNC. Separately, 5 bits followed by a gap -> err and no frame_done.
- Mid-frame reset: assert rst after 3 bytes -> outputs at reset values; a fresh frame after a 2500-cycle gap decodes from address 0.

Source files
------------

// File: rtl/everloop_rx.sv
// everloop_rx: receive end of the everloop single-wire NRZ LED link.
// Measures high-pulse widths on the synchronized line, recovers bits MSB-first,
// assembles bytes and writes them out on an address/data_RGB/wr_en port.
// Optional build macro: EVERLOOP_RX_GLITCH_EN (high pulses shorter than 4 cycles
// are treated as line noise instead of decoding as 0 bits).
module everloop_rx #(
  parameter int unsigned HI_THRESH  = 28,
  parameter int unsigned MAX_HI     = 60,
  parameter int unsigned RST_CYCLES = 2500,
  parameter int unsigned NUM_BYTES  = 140,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              everloop_d,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        data_RGB,
  output logic              wr_en,
  output logic              frame_done,
  output logic              overflow,
  output logic              err
);

  localparam int unsigned HI_W = $clog2(MAX_HI + 2);
  localparam int unsigned LO_W = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t            state, state_n;
  logic              d_meta, d_s, d_s_q;
  logic [HI_W-1:0]   hi_cnt, hi_n;
  logic [LO_W-1:0]   lo_cnt, lo_n;
  logic [3:0]        bit_cnt, bit_n;
  logic [7:0]        shreg, sh_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        data_n;
  logic              wr_n, fd_n, ovf_n, err_n;
  logic              rise_c, fall_c, bit_c, glitch_c;
  logic [LO_W-1:0]   lo_inc_c;

  assign rise_c   = d_s & ~d_s_q;
  assign fall_c   = ~d_s & d_s_q;
  assign bit_c    = (hi_cnt >= HI_W'(HI_THRESH));
  assign lo_inc_c = (lo_cnt >= LO_W'(RST_CYCLES)) ? lo_cnt : lo_cnt + LO_W'(1);

`ifdef EVERLOOP_RX_GLITCH_EN
  assign glitch_c = (hi_cnt < HI_W'(4));
`else
  assign glitch_c = 1'b0;
`endif

  // Synchronizer, edge-detect history, FSM state and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      d_meta     <= 1'b0;
      d_s        <= 1'b0;
      d_s_q      <= 1'b0;
      state      <= SYNC;
      hi_cnt     <= '0;
      lo_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      address    <= '0;
      data_RGB   <= '0;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      err        <= 1'b0;
    end else begin
      d_meta     <= everloop_d;
      d_s        <= d_meta;
      d_s_q      <= d_s;
      state      <= state_n;
      hi_cnt     <= hi_n;
      lo_cnt     <= lo_n;
      bit_cnt    <= bit_n;
      shreg      <= sh_n;
      address    <= addr_n;
      data_RGB   <= data_n;
      wr_en      <= wr_n;
      frame_done <= fd_n;
      overflow   <= ovf_n;
      err        <= err_n;
    end
  end

  // Next-state, pulse timing, byte assembly and write/end-of-frame decisions
  always_comb begin
    state_n = state;
    hi_n    = hi_cnt;
    lo_n    = lo_cnt;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    addr_n  = address;
    data_n  = data_RGB;
    wr_n    = 1'b0;
    fd_n    = 1'b0;
    ovf_n   = overflow;
    err_n   = 1'b0;

    // Address advances the cycle after a write strobe; it never passes NUM_BYTES
    if (wr_en) begin
      addr_n = address + ADDR_W'(1);
    end

    // A completed byte is written one cycle after its last bit was shifted in
    if (bit_cnt == 4'd8) begin
      bit_n = '0;
      if (address == ADDR_W'(NUM_BYTES)) begin
        ovf_n = 1'b1;
      end else begin
        wr_n   = 1'b1;
        data_n = shreg;
      end
    end

    case (state)
      SYNC: begin
        if (d_s) begin
          lo_n = '0;
        end else if (lo_cnt >= LO_W'(RST_CYCLES - 1)) begin
          lo_n    = '0;
          state_n = IDLE;
        end else begin
          lo_n = lo_cnt + LO_W'(1);
        end
      end

      IDLE: begin
        if (rise_c) begin
          hi_n    = HI_W'(1);
          state_n = HIGH;
        end
      end

      HIGH: begin
`ifdef EVERLOOP_RX_GLITCH_EN
        lo_n = lo_inc_c;
`endif
        if (hi_cnt > HI_W'(MAX_HI)) begin
          err_n   = 1'b1;
          bit_n   = '0;
          sh_n    = '0;
          addr_n  = '0;
          lo_n    = '0;
          state_n = SYNC;
        end else if (fall_c && !glitch_c) begin
          sh_n    = {shreg[6:0], bit_c};
          bit_n   = bit_cnt + 4'd1;
          lo_n    = LO_W'(1);
          state_n = LOW;
        end else if (fall_c) begin
          state_n = LOW;
        end else begin
          hi_n = hi_cnt + HI_W'(1);
        end
      end

      LOW: begin
        lo_n = lo_inc_c;
        if (rise_c) begin
          hi_n    = HI_W'(1);
          state_n = HIGH;
        end else if (lo_cnt >= LO_W'(RST_CYCLES - 1)) begin
          err_n   = (bit_cnt != 4'd0);
          fd_n    = (address != '0);
          addr_n  = '0;
          ovf_n   = 1'b0;
          bit_n   = '0;
          sh_n    = '0;
          lo_n    = '0;
          state_n = IDLE;
        end
      end

      default: state_n = SYNC;
    endcase
  end

endmodule
